// File: rtl/cond_exec_if.sv
// -----------------------------------------------------------------------------
// cond_exec_if
// Bundle of the Execute-stage signals around cond_exec_stage.
//   master : pipeline side. It drives the D/E-register controls, the E-stage
//            datapath values and FlushM. It observes the condition result,
//            the flags and the M-stage register.
//   slave  : cond_exec_stage itself.
// E-side : FlushM, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE,
//          FlagWriteE[1:0], CondE[3:0], RdE[3:0], ALUFlagsE[3:0],
//          ALUResultE/WriteDataE[WIDTH-1:0]
// Results: CondExE, BranchTakenE, FlagsE[3:0]
// M-side : PCSrcM, RegWriteM, MemtoRegM, MemWriteM, RdM[3:0],
//          ALUResultM/WriteDataM[WIDTH-1:0]
// -----------------------------------------------------------------------------
interface cond_exec_if #(
    parameter int WIDTH = 32
);
    logic             FlushM;
    logic             PCSrcE;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic             MemWriteE;
    logic             BranchE;
    logic [1:0]       FlagWriteE;
    logic [3:0]       CondE;
    logic [3:0]       RdE;
    logic [3:0]       ALUFlagsE;
    logic [WIDTH-1:0] ALUResultE;
    logic [WIDTH-1:0] WriteDataE;

    logic             CondExE;
    logic             BranchTakenE;
    logic [3:0]       FlagsE;

    logic             PCSrcM;
    logic             RegWriteM;
    logic             MemtoRegM;
    logic             MemWriteM;
    logic [3:0]       RdM;
    logic [WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0] WriteDataM;

    modport master (
        output FlushM, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE,
               FlagWriteE, CondE, RdE, ALUFlagsE, ALUResultE, WriteDataE,
        input  CondExE, BranchTakenE, FlagsE,
               PCSrcM, RegWriteM, MemtoRegM, MemWriteM, RdM,
               ALUResultM, WriteDataM
    );

    modport slave (
        input  FlushM, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE,
               FlagWriteE, CondE, RdE, ALUFlagsE, ALUResultE, WriteDataE,
        output CondExE, BranchTakenE, FlagsE,
               PCSrcM, RegWriteM, MemtoRegM, MemWriteM, RdM,
               ALUResultM, WriteDataM
    );
endinterface

// File: rtl/cond_exec_stage.sv
// -----------------------------------------------------------------------------
// cond_exec_stage
// Execute stage of the ARM pipeline. The block:
//   - holds the architectural NZCV flag register
//   - evaluates CondE against that register
//   - squashes PCSrc, RegWrite, MemWrite and FlagWrite when the condition fails
//   - registers the surviving controls and the datapath values into M
// Ports:
//   clk   : clock
//   reset : asynchronous reset, active-high
//   bus   : cond_exec_if.slave. It carries the E inputs, CondExE,
//           BranchTakenE, FlagsE and the M-stage register outputs.
// -----------------------------------------------------------------------------
module cond_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    cond_exec_if.slave  bus
);
    logic [3:0]       r_flags;        // {N,Z,C,V}
    logic             r_pcsrc_m;
    logic             r_regwrite_m;
    logic             r_memtoreg_m;
    logic             r_memwrite_m;
    logic [3:0]       r_rd_m;
    logic [WIDTH-1:0] r_aluresult_m;
    logic [WIDTH-1:0] r_writedata_m;

    logic w_n, w_z, w_c, w_v;
    logic w_cond_ex;
    logic w_wr_nz, w_wr_cv;
    logic w_keep_ctl;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // The condition uses the registered flags only. An instruction's own
    // ALUFlagsE therefore never feeds back into its own condition.
    always_comb begin
        w_cond_ex = 1'b0;
        case (bus.CondE)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            default: w_cond_ex = 1'b1;  // AL, and 1111 treated as always
        endcase
    end

    assign w_wr_nz    = bus.FlagWriteE[1] & w_cond_ex;
    assign w_wr_cv    = bus.FlagWriteE[0] & w_cond_ex;
    assign w_keep_ctl = ~bus.FlushM;

    // The two flag halves update independently. FlushM does not affect them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (w_wr_nz) r_flags[3:2] <= bus.ALUFlagsE[3:2];
            if (w_wr_cv) r_flags[1:0] <= bus.ALUFlagsE[1:0];
        end
    end

    // The M register loads every cycle. FlushM clears only the controls;
    // Rd and the data words still load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcsrc_m     <= 1'b0;
            r_regwrite_m  <= 1'b0;
            r_memtoreg_m  <= 1'b0;
            r_memwrite_m  <= 1'b0;
            r_rd_m        <= '0;
            r_aluresult_m <= '0;
            r_writedata_m <= '0;
        end else begin
            r_pcsrc_m     <= w_keep_ctl & bus.PCSrcE & w_cond_ex;
            r_regwrite_m  <= w_keep_ctl & bus.RegWriteE & w_cond_ex;
            r_memtoreg_m  <= w_keep_ctl & bus.MemtoRegE;
            r_memwrite_m  <= w_keep_ctl & bus.MemWriteE & w_cond_ex;
            r_rd_m        <= bus.RdE;
            r_aluresult_m <= bus.ALUResultE;
            r_writedata_m <= bus.WriteDataE;
        end
    end

    assign bus.CondExE      = w_cond_ex;
    assign bus.BranchTakenE = bus.BranchE & w_cond_ex;
    assign bus.FlagsE       = r_flags;
    assign bus.PCSrcM       = r_pcsrc_m;
    assign bus.RegWriteM    = r_regwrite_m;
    assign bus.MemtoRegM    = r_memtoreg_m;
    assign bus.MemWriteM    = r_memwrite_m;
    assign bus.RdM          = r_rd_m;
    assign bus.ALUResultM   = r_aluresult_m;
    assign bus.WriteDataM   = r_writedata_m;
endmodule

// File: tb/tb_cond_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_cond_exec_stage
// Self-checking bench for cond_exec_stage.
// Each E-stage transaction pushes its predicted M-stage contents to a queue.
// The entry is popped and compared after the capturing edge. A separate flag
// model predicts FlagsE.
// -----------------------------------------------------------------------------
module tb_cond_exec_stage;
    localparam int WIDTH = 32;

    typedef struct packed {
        logic             pcsrc;
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic [3:0]       rd;
        logic [WIDTH-1:0] alu;
        logic [WIDTH-1:0] wd;
    } m_exp_t;

    logic clk;
    logic reset;
    cond_exec_if #(.WIDTH(WIDTH)) bus ();

    cond_exec_stage #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp;
    int     n_err;
    m_exp_t sb_q[$];
    logic [3:0] m_flags;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference condition in ARM encoding form: base test on c[3:1],
    // inverted by c[0] except for the always group.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && c[3:1] != 3'd7) r = !r;
        return r;
    endfunction

    task automatic chk_m(input string tag, input m_exp_t e);
        chk({tag, ".PCSrcM"},     bus.PCSrcM,     e.pcsrc);
        chk({tag, ".RegWriteM"},  bus.RegWriteM,  e.regwrite);
        chk({tag, ".MemtoRegM"},  bus.MemtoRegM,  e.memtoreg);
        chk({tag, ".MemWriteM"},  bus.MemWriteM,  e.memwrite);
        chk({tag, ".RdM"},        bus.RdM,        e.rd);
        chk({tag, ".ALUResultM"}, bus.ALUResultM, e.alu);
        chk({tag, ".WriteDataM"}, bus.WriteDataM, e.wd);
    endtask

    // Drive one E-stage instruction at the negedge and check the
    // combinational outputs. Then check M and the flags after the posedge.
    task automatic step(input string tag, input logic fl, input logic pc, input logic rw,
                        input logic mr, input logic mw, input logic br,
                        input logic [1:0] fw, input logic [3:0] cond, input logic [3:0] rd,
                        input logic [3:0] af, input logic [WIDTH-1:0] alu,
                        input logic [WIDTH-1:0] wd);
        logic   ok;
        m_exp_t e;
        @(negedge clk);
        bus.FlushM = fl; bus.PCSrcE = pc; bus.RegWriteE = rw; bus.MemtoRegE = mr;
        bus.MemWriteE = mw; bus.BranchE = br; bus.FlagWriteE = fw; bus.CondE = cond;
        bus.RdE = rd; bus.ALUFlagsE = af; bus.ALUResultE = alu; bus.WriteDataE = wd;
        #1;
        ok = cond_ok(cond, m_flags);
        chk({tag, ".CondExE"},      bus.CondExE,      ok);
        chk({tag, ".BranchTakenE"}, bus.BranchTakenE, br & ok);
        e.pcsrc    = !fl && pc && ok;
        e.regwrite = !fl && rw && ok;
        e.memtoreg = !fl && mr;
        e.memwrite = !fl && mw && ok;
        e.rd = rd; e.alu = alu; e.wd = wd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (fw[1] && ok) m_flags[3:2] = af[3:2];
        if (fw[0] && ok) m_flags[1:0] = af[1:0];
        chk_m(tag, sb_q.pop_front());
        chk({tag, ".FlagsE"}, bus.FlagsE, m_flags);
    endtask

    task automatic chk_cleared(input string tag);
        m_exp_t z;
        z = '0;
        chk({tag, ".FlagsE"}, bus.FlagsE, 4'b0000);
        chk_m(tag, z);
    endtask

    // Load the flag register through an AL instruction with no side effects.
    task automatic set_flags(input logic [3:0] f);
        step("setf", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'hE, 4'h0, f, '0, '0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; m_flags = 4'b0000;
        reset = 1'b1;
        bus.FlushM = 0; bus.PCSrcE = 0; bus.RegWriteE = 0; bus.MemtoRegE = 0;
        bus.MemWriteE = 0; bus.BranchE = 0; bus.FlagWriteE = 0; bus.CondE = 0;
        bus.RdE = 0; bus.ALUFlagsE = 0; bus.ALUResultE = 0; bus.WriteDataE = 0;
        #12;
        chk_cleared("reset");
        @(negedge clk);
        reset = 1'b0;

        // Flag set/use
        set_flags(4'b0100);
        step("eq_use", 0, 0, 1, 0, 0, 0, 2'b00, 4'b0000, 4'h3, 4'h0, 32'h11, 32'h22);
        step("ne_use", 0, 0, 1, 0, 0, 0, 2'b00, 4'b0001, 4'h4, 4'h0, 32'h33, 32'h44);

        // Condition sweep, combinational only
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                bus.FlagWriteE = 2'b00;
                bus.CondE = 4'(c);
                #1;
                chk($sformatf("sweep.f%0h.c%0h", f, c), bus.CondExE, cond_ok(4'(c), 4'(f)));
            end
        end
        set_flags(4'b1001);  // N=1 V=1 Z=0: GT passes, LE fails
        step("gt", 0, 0, 1, 0, 0, 0, 2'b00, 4'b1100, 4'h1, 4'h0, 32'h1, 32'h0);
        step("le", 0, 0, 1, 0, 0, 0, 2'b00, 4'b1101, 4'h2, 4'h0, 32'h2, 32'h0);

        // Partial flag write
        set_flags(4'b1111);
        step("cv_only", 0, 0, 0, 0, 0, 0, 2'b01, 4'hE, 4'h0, 4'b0000, '0, '0);
        set_flags(4'b1111);
        step("cv_fail", 0, 0, 0, 0, 0, 0, 2'b01, 4'b0001, 4'h0, 4'b0000, '0, '0);

        // Failed store and branch still carry data into M
        set_flags(4'b0000);
        step("fail_st", 0, 1, 0, 0, 1, 1, 2'b00, 4'b0000, 4'h7, 4'h0, 32'hDEADBEEF, 32'hCAFEF00D);

        // Flush with a flag-setting instruction
        step("flush", 1, 0, 1, 1, 1, 0, 2'b11, 4'hE, 4'h9, 4'b1010, 32'h12345678, 32'h9ABCDEF0);

        // Async reset mid-stream with a nonzero state present
        step("pre_rst", 0, 1, 1, 1, 1, 0, 2'b00, 4'hE, 4'hF, 4'h0, 32'hFFFF0000, 32'h0000FFFF);
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_flags = 4'b0000;
        chk_cleared("async_rst");
        @(posedge clk);
        #1;
        chk_cleared("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", 0, 0, 1, 1, 0, 0, 2'b10, 4'hE, 4'h5, 4'b1100, 32'hA5A5A5A5, 32'h5A5A5A5A);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                 4'($urandom), $urandom, $urandom);
        end

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
